// File: rtl/phase_sequencer_ctrl.sv
// Phase sequencer: steps phase 0..PHASES-1, holding each for a programmable dwell,
// with pause/abort control and one-shot or looping operation.
module phase_sequencer_ctrl #(
    parameter int PHASES = 7,
    parameter int CW     = 4,
    parameter int DW     = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          pause,
    input  logic          abort,
    input  logic          loop,
    input  logic          cfg_we,
    input  logic [2:0]    cfg_addr,
    input  logic [DW-1:0] cfg_data,
    output logic [CW-1:0] phase,
    output logic          busy,
    output logic          phase_tick,
    output logic          done
);

    localparam int AW = (PHASES > 1) ? $clog2(PHASES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t        state_q;
    logic [CW-1:0] phase_q;
    logic [DW-1:0] timer_q;
    logic          busy_q;
    logic          tick_q;
    logic          done_q;
    logic [DW-1:0] dwell_q [PHASES];

    logic          last_phase_d;
    logic [CW-1:0] phase_d;
    logic [DW-1:0] reload_d;
    logic [DW-1:0] cfg_val_d;
    logic [AW-1:0] cfg_idx_d;

    assign last_phase_d = (phase_q == CW'(PHASES - 1));
    assign phase_d      = last_phase_d ? '0 : phase_q + CW'(1);
    assign reload_d     = dwell_q[AW'(phase_d)];
    assign cfg_val_d    = (cfg_data == '0) ? DW'(1) : cfg_data;
    assign cfg_idx_d    = AW'(cfg_addr);

    // Dwell table stores the already-clamped value so the timer never loads 0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < PHASES; i++) begin
                dwell_q[i] <= DW'(1);
            end
        end else if (cfg_we && (int'(cfg_addr) < PHASES)) begin
            dwell_q[cfg_idx_d] <= cfg_val_d;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            phase_q <= '0;
            timer_q <= '0;
            busy_q  <= 1'b0;
            tick_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= RUN;
                        phase_q <= '0;
                        timer_q <= dwell_q[0];
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        phase_q <= '0;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (pause) begin
                        state_q <= HOLD;
                    end else if (timer_q <= DW'(1)) begin
                        // Last cycle of the phase: advance, wrap, or finish.
                        if (!last_phase_d || loop) begin
                            phase_q <= phase_d;
                            timer_q <= reload_d;
                            tick_q  <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                            phase_q <= '0;
                            timer_q <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end
                    end else begin
                        timer_q <= timer_q - DW'(1);
                    end
                end
                HOLD: begin
                    if (abort) begin
                        state_q <= IDLE;
                        phase_q <= '0;
                        timer_q <= '0;
                        busy_q  <= 1'b0;
                    end else if (!pause) begin
                        state_q <= RUN;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    phase_q <= '0;
                    timer_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign phase      = phase_q;
    assign busy       = busy_q;
    assign phase_tick = tick_q;
    assign done       = done_q;

endmodule

// File: tb/tb_phase_sequencer_ctrl.sv
// Bench for phase_sequencer_ctrl: per-cycle comparison against a dwell-count model,
// plus hand-computed checkpoints for each directed scenario.
module tb_phase_sequencer_ctrl;

    localparam int PHASES = 7;
    localparam int CW     = 4;
    localparam int DW     = 8;

    logic          clk;
    logic          reset;
    logic          start;
    logic          pause;
    logic          abort;
    logic          loop;
    logic          cfg_we;
    logic [2:0]    cfg_addr;
    logic [DW-1:0] cfg_data;
    logic [CW-1:0] phase;
    logic          busy;
    logic          phase_tick;
    logic          done;

    int n_chk  = 0;
    int n_fail = 0;

    // Model: whether a sequence is active, whether it is paused, the phase,
    // how many running cycles the phase has used, and the length it was entered with.
    bit m_run;
    bit m_held;
    int m_phase;
    int m_used;
    int m_target;
    bit m_tick;
    bit m_done;
    int m_tbl [PHASES];

    phase_sequencer_ctrl #(.PHASES(PHASES), .CW(CW), .DW(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .pause      (pause),
        .abort      (abort),
        .loop       (loop),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .phase      (phase),
        .busy       (busy),
        .phase_tick (phase_tick),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_len(input int raw);
        return (raw == 0) ? 1 : raw;
    endfunction

    task automatic model_reset();
        m_run = 0; m_held = 0; m_phase = 0; m_used = 0; m_target = 0;
        m_tick = 0; m_done = 0;
        for (int i = 0; i < PHASES; i++) m_tbl[i] = 1;
    endtask

    task automatic model_enter(input int p);
        m_phase  = p;
        m_used   = 0;
        m_target = eff_len(m_tbl[p]);
    endtask

    task automatic model_step();
        m_tick = 0;
        m_done = 0;
        if (!m_run) begin
            if (start && !abort) begin
                m_run = 1; m_held = 0;
                model_enter(0);
            end
        end else if (abort) begin
            m_run = 0; m_held = 0; m_phase = 0;
        end else if (m_held) begin
            if (!pause) m_held = 0;
        end else if (pause) begin
            m_held = 1;
        end else begin
            m_used++;
            if (m_used >= m_target) begin
                if (m_phase < PHASES - 1) begin
                    model_enter(m_phase + 1);
                    m_tick = 1;
                end else if (loop) begin
                    model_enter(0);
                    m_tick = 1;
                end else begin
                    m_run = 0; m_phase = 0; m_done = 1;
                end
            end
        end
        // Table write lands after this edge's reload decisions.
        if (cfg_we && int'(cfg_addr) < PHASES) m_tbl[cfg_addr] = int'(cfg_data);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("model_phase", int'(phase), m_phase);
            chk("model_busy", int'(busy), int'(m_run));
            chk("model_tick", int'(phase_tick), int'(m_tick));
            chk("model_done", int'(done), int'(m_done));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic cfg_write(input int addr, input int data);
        cfg_we = 1'b1; cfg_addr = 3'(addr); cfg_data = DW'(data);
        cyc();
        cfg_we = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (!done && cycles < limit) begin
            cyc();
            cycles++;
        end
    endtask

    int c;

    initial begin
        reset = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; loop = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
        repeat (3) cyc();
        chk("rst_phase", int'(phase), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        reset = 1'b1;
        cyc();

        // Default table, one-shot
        start_pulse();
        for (int k = 1; k <= 7; k++) begin
            chk("t1_phase", int'(phase), k - 1);
            chk("t1_tick", int'(phase_tick), (k >= 2) ? 1 : 0);
            cyc();
        end
        chk("t1_done", int'(done), 1);
        chk("t1_busy_end", int'(busy), 0);
        chk("t1_phase_end", int'(phase), 0);
        cyc();

        // Programmed dwell, including a zero entry
        cfg_write(2, 3);
        cfg_write(5, 0);
        start_pulse();
        wait_done(40, c);
        chk("t2_done_cycle", c + 1, 10);
        cyc();
        cfg_write(2, 1);
        cfg_write(5, 1);

        // Looping, three wraps, then drop loop
        loop = 1'b1;
        start_pulse();
        repeat (7) cyc();
        chk("t3_wrap1_phase", int'(phase), 0);
        chk("t3_wrap1_tick", int'(phase_tick), 1);
        chk("t3_wrap1_done", int'(done), 0);
        repeat (14) cyc();
        chk("t3_wrap3_phase", int'(phase), 0);
        chk("t3_wrap3_tick", int'(phase_tick), 1);
        chk("t3_wrap3_busy", int'(busy), 1);
        loop = 1'b0;
        repeat (7) cyc();
        chk("t3_done", int'(done), 1);
        chk("t3_busy", int'(busy), 0);
        cyc();

        // Pause in the middle of a 4-cycle phase
        cfg_write(1, 4);
        start_pulse();
        repeat (3) cyc();
        pause = 1'b1;
        repeat (5) begin
            cyc();
            chk("t4_hold_phase", int'(phase), 1);
            chk("t4_hold_tick", int'(phase_tick), 0);
        end
        pause = 1'b0;
        repeat (2) begin
            cyc();
            chk("t4_resume_phase", int'(phase), 1);
        end
        cyc();
        chk("t4_adv_phase", int'(phase), 2);
        chk("t4_adv_tick", int'(phase_tick), 1);
        wait_done(30, c);
        chk("t4_done_seen", int'(done), 1);
        cfg_write(1, 1);

        // Abort from RUN, start ignored while busy, abort from HOLD, abort+start
        start_pulse();
        repeat (4) cyc();
        chk("t5_phase4", int'(phase), 4);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("t5_abort_phase", int'(phase), 0);
        chk("t5_abort_busy", int'(busy), 0);
        chk("t5_abort_done", int'(done), 0);
        start_pulse();
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("t5_ign_phase", int'(phase), 1);
        pause = 1'b1;
        repeat (2) cyc();
        chk("t5_hold_phase", int'(phase), 1);
        abort = 1'b1;
        cyc();
        abort = 1'b0; pause = 1'b0;
        chk("t5_hold_abort_busy", int'(busy), 0);
        chk("t5_hold_abort_phase", int'(phase), 0);
        abort = 1'b1; start = 1'b1;
        cyc();
        abort = 1'b0; start = 1'b0;
        chk("t5_both_busy", int'(busy), 0);
        cyc();
        chk("t5_noqueue_busy", int'(busy), 0);

        // Asynchronous reset mid-sequence clears outputs and the table
        cfg_write(3, 9);
        start_pulse();
        repeat (3) cyc();
        chk("t6_phase3", int'(phase), 3);
        #2 reset = 1'b0;
        #1;
        chk("t6_async_phase", int'(phase), 0);
        chk("t6_async_busy", int'(busy), 0);
        cyc();
        reset = 1'b1;
        cyc();
        cfg_write(7, 5);
        start_pulse();
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_data = 8'd3;
        cyc();
        cfg_we = 1'b0;
        chk("t6_phase1", int'(phase), 1);
        wait_done(40, c);
        chk("t6_done_cycle", c + 2, 8);
        cyc();
        start_pulse();
        wait_done(40, c);
        chk("t6_new_dwell_cycle", c + 1, 10);
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/phase_sequencer_ctrl.md
Name: phase_sequencer_ctrl

Overview:
Controller that sequences the 7-step phase counter (phases 0..6, wrap after 6) used across the design, holding each phase for a programmable number of clock cycles. Supports start, pause, abort and a one-shot or looping mode. Exposes the current phase plus per-phase and end-of-sequence strobes to downstream logic such as display and actuator drivers. A small configuration table holds the dwell time for each phase.

Parameters:
PHASES, 7, number of phases; phase runs 0..PHASES-1 then wraps to 0
CW, 4, phase output width; must satisfy 2^CW >= PHASES
DW, 8, dwell-time width in cycles per phase

Ports:
clk  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
start  in  1  begin a sequence; sampled only in IDLE
pause  in  1  level; freezes the sequence while high
abort  in  1  level/pulse; returns to IDLE from any state
loop  in  1  at the end of phase PHASES-1: 1 = wrap to phase 0 and continue, 0 = finish
cfg_we  in  1  dwell table write enable
cfg_addr  in  3  dwell table index
cfg_data  in  DW  dwell value in cycles; 0 is treated as 1
phase  out  CW  current phase, registered
busy  out  1  high in RUN and HOLD
phase_tick  out  1  one-cycle pulse in the first cycle a new phase is visible, including the wrap to 0
done  out  1  one-cycle pulse when a non-loop sequence completes

Behaviour:
- Reset, asynchronous, while reset=0:
  - state=IDLE, phase=0, busy=0, phase_tick=0, done=0, internal timer=0.
  - All dwell entries reset to 1.
- States: IDLE, RUN, HOLD. Priority each cycle: abort > pause > phase-end > start.
- IDLE:
  - start=1 and abort=0 -> RUN on the next edge, with phase=0, timer=dwell[0], busy=1.
  - phase_tick is not asserted for the initial phase 0.
- RUN:
  - The timer decrements each cycle. Phase p is visible for exactly max(dwell[p],1) cycles.
  - On the last cycle of a phase with p < PHASES-1: next phase = p+1, timer reloads from dwell[p+1], phase_tick=1 for one cycle.
  - On the last cycle of phase PHASES-1 with loop=1: phase=0, reload dwell[0], phase_tick=1.
  - On the last cycle of phase PHASES-1 with loop=0: -> IDLE, phase=0, busy=0, done=1 for one cycle.
  - loop is sampled only on that last cycle.
- HOLD:
  - Entered from RUN when pause=1 and abort=0. Timer and phase are frozen and no strobes fire.
  - Returns to RUN the cycle after pause falls; the remaining dwell count is preserved exactly.
  - pause=1 on the last cycle of a phase freezes the phase; it does not advance.
- abort=1 in RUN or HOLD -> IDLE next edge, phase=0, busy=0, done=0, no phase_tick.
- abort=1 together with start in IDLE: stays IDLE.
- start while busy=1 is ignored and is not queued.
- Config writes:
  - Accepted in any state; a write updates the entry on the next edge.
  - cfg_addr >= PHASES is ignored.
  - Writing the active phase's entry does not change the timer already loaded; it takes effect on the next entry into that phase.
  - A write on the same edge that the timer reloads from that entry loads the old value.
- Arithmetic:
  - Timer width is DW, so the maximum dwell is 2^DW-1 cycles.
  - Phase increment is modulo PHASES. phase never takes a value >= PHASES.
- Outputs are all registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset, default table, start pulse at cycle 0 with loop=0 -> phase = 0,1,2,3,4,5,6 for 1 cycle each over cycles 1..7; phase_tick on cycles 2..7; done=1 and busy=0 at cycle 8, phase=0.
- Write dwell[2]=3 and dwell[5]=0, then start with loop=0 -> phase 2 visible for 3 cycles, phase 5 for 1 cycle; done at cycle 10 after start.
- loop=1 with the default table -> after phase 6 comes phase 0 with phase_tick=1 and no done; busy stays 1 across 3 full wraps; drop loop -> done after the next phase 6.
- dwell[1]=4; pause raised after 2 cycles in phase 1 and held for 5 cycles -> phase stays 1 and no strobes fire; after release, 2 more cycles of phase 1, then phase_tick with phase=2.
- abort in phase 4 and in HOLD, then abort+start together in IDLE -> IDLE next cycle, phase=0, busy=0, no done; the simultaneous case stays IDLE; start during RUN is ignored.
- Assert reset mid-sequence in phase 3, with dwell[3]=9 -> outputs clear immediately (asynchronously) and the table returns to all 1s; the next start runs 1-cycle phases.
